// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver: deserializes the 2-bit pixel link into frame-buffer writes.
// A packet is a 24-bit start address (3 bytes, MSB byte first) followed by
// PIXELS_PER_PKT pixel bytes; any trailing bytes are dropped. Each byte arrives
// as 4 dibits, least significant dibit first.
module pixel_stream_receiver #(
  parameter int PIXELS_PER_PKT = 320,
  parameter int FRAME_PIXELS   = 76800,
  parameter int ADDR_W         = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  output logic              pixel_we,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_data,
  output logic [23:0]       pkt_addr,
  output logic              pkt_done,
  output logic              pkt_error
);

  localparam int                IDX_W    = $clog2(PIXELS_PER_PKT + 1);
  localparam int                SUM_W    = ADDR_W + 1;
  localparam logic [SUM_W-1:0]  FP_S     = SUM_W'(FRAME_PIXELS);
  localparam logic [23:0]       FP_A     = 24'(FRAME_PIXELS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIXELS_PER_PKT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PIX, S_DRAIN} state_t;

  state_t            state, state_n;
  logic              axiiv_q;
  logic [3:0]        dib_cnt;   // dibit index: 0..11 in address, 0..3 in a pixel
  logic [7:0]        sh8;       // byte assembly, new dibit enters at the top
  logic [15:0]       addr_sh;   // first two completed address bytes
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  pix_idx;

  logic              start, byte_end;
  logic [7:0]        byte_full;
  logic [23:0]       addr_full;
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W-1:0] addr_mod;
  logic              load_pa, we_n, done_n, err_n;

  // A packet only starts on a rising edge of axiiv, so a link that stays high
  // across reset is not mistaken for a fresh packet.
  assign start     = axiiv & ~axiiv_q;
  assign byte_end  = (dib_cnt[1:0] == 2'd3);
  // Byte completed by the dibit on the wire this cycle.
  assign byte_full = {axiid, sh8[7:2]};
  assign addr_full = {addr_sh, byte_full};
  // Both operands are below FRAME_PIXELS, so one conditional subtract wraps.
  assign sum       = {1'b0, base} + SUM_W'(pix_idx);
  assign addr_mod  = (sum >= FP_S) ? ADDR_W'(sum - FP_S) : ADDR_W'(sum);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_n = state;
    load_pa = 1'b0;
    we_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_ADDR;
      end
      S_ADDR: begin
        if (!axiiv) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (dib_cnt == 4'd11) begin
          load_pa = 1'b1;
          if (addr_full >= FP_A) begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end else begin
            state_n = S_PIX;
          end
        end
      end
      S_PIX: begin
        if (!axiiv) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (byte_end) begin
          we_n = 1'b1;
          if (pix_idx == LAST_IDX) begin
            done_n  = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!axiiv) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Dibit capture, address assembly and pixel index
  always_ff @(posedge clk) begin
    axiiv_q <= axiiv;
    if (rst) begin
      dib_cnt <= '0;
      sh8     <= '0;
      addr_sh <= '0;
      base    <= '0;
      pix_idx <= '0;
    end else begin
      if (axiiv) sh8 <= {axiid, sh8[7:2]};
      unique case (state)
        S_IDLE: begin
          dib_cnt <= start ? 4'd1 : 4'd0;
          addr_sh <= '0;
          pix_idx <= '0;
        end
        S_ADDR: begin
          if (!axiiv || dib_cnt == 4'd11) begin
            dib_cnt <= '0;
          end else begin
            dib_cnt <= dib_cnt + 4'd1;
            if (byte_end) addr_sh <= {addr_sh[7:0], byte_full};
          end
        end
        S_PIX: begin
          if (!axiiv) begin
            dib_cnt <= '0;
          end else begin
            dib_cnt <= byte_end ? 4'd0 : dib_cnt + 4'd1;
            if (we_n) pix_idx <= pix_idx + IDX_W'(1);
          end
        end
        default: dib_cnt <= '0;
      endcase
      if (load_pa) base <= addr_full[ADDR_W-1:0];
    end
  end

  // Registered outputs; write address/data hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_we   <= 1'b0;
      pixel_addr <= '0;
      pixel_data <= '0;
      pkt_addr   <= '0;
      pkt_done   <= 1'b0;
      pkt_error  <= 1'b0;
    end else begin
      pixel_we  <= we_n;
      pkt_done  <= done_n;
      pkt_error <= err_n;
      if (load_pa) pkt_addr <= addr_full;
      if (we_n) begin
        pixel_addr <= addr_mod;
        pixel_data <= byte_full;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench for pixel_stream_receiver with 4 pixels per packet.
module tb_pixel_stream_receiver;

  localparam int PPP = 4;
  localparam int FP  = 76800;
  localparam int AW  = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          axiiv;
  logic [1:0]    axiid;
  logic          pixel_we;
  logic [AW-1:0] pixel_addr;
  logic [7:0]    pixel_data;
  logic [23:0]   pkt_addr;
  logic          pkt_done;
  logic          pkt_error;

  pixel_stream_receiver #(
    .PIXELS_PER_PKT(PPP),
    .FRAME_PIXELS  (FP),
    .ADDR_W        (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axiiv     (axiiv),
    .axiid     (axiid),
    .pixel_we  (pixel_we),
    .pixel_addr(pixel_addr),
    .pixel_data(pixel_data),
    .pkt_addr  (pkt_addr),
    .pkt_done  (pkt_done),
    .pkt_error (pkt_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Event log, sampled 1 time unit after each rising edge
  int            done_cnt, done_on_we, err_cnt;
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];
  int            log_cyc[$];
  int            err_cyc[$];
  int            pix_cyc[$];   // cycle in which each pixel's last dibit was driven

  always @(posedge clk) begin
    #1;
    cyc++;
    if (pixel_we) begin
      log_addr.push_back(pixel_addr);
      log_data.push_back(pixel_data);
      log_cyc.push_back(cyc);
    end
    if (pkt_done) begin
      done_cnt++;
      if (pixel_we) done_on_we++;
    end
    if (pkt_error) begin
      err_cnt++;
      err_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    err_cyc.delete(); pix_cyc.delete();
    done_cnt = 0; done_on_we = 0; err_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    @(negedge clk);
    axiiv = v;
    axiid = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 0; j < 4; j++) drive(1'b1, b[2*j +: 2]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic send_pixel(input logic [7:0] b);
    send_byte(b);
    pix_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  // Compares the write log against nwr expected (addr, data) pairs and 1-cycle latency
  task automatic check_writes(input string name, input int nwr,
                              input logic [AW-1:0] ea [4], input logic [7:0] ed [4]);
    checks++;
    if (log_addr.size() !== nwr) begin
      errors++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, log_addr.size(), nwr);
    end
    for (int i = 0; i < nwr && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL %s addr[%0d] got=%0d exp=%0d", name, i, log_addr[i], ea[i]);
      end
      checks++;
      if (log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL %s data[%0d] got=%h exp=%h", name, i, log_data[i], ed[i]);
      end
      if (i < pix_cyc.size()) begin
        checks++;
        if (log_cyc[i] !== pix_cyc[i] + 1) begin
          errors++;
          $display("FAIL %s latency[%0d] we_cyc=%0d exp=%0d", name, i, log_cyc[i], pix_cyc[i] + 1);
        end
      end
    end
  endtask

  task automatic check_counts(input string name, input int edone, input int eerr);
    checks++;
    if (done_cnt !== edone) begin
      errors++;
      $display("FAIL %s done_count got=%0d exp=%0d", name, done_cnt, edone);
    end
    checks++;
    if (done_on_we !== edone) begin
      errors++;
      $display("FAIL %s done_with_last_we got=%0d exp=%0d", name, done_on_we, edone);
    end
    checks++;
    if (err_cnt !== eerr) begin
      errors++;
      $display("FAIL %s error_count got=%0d exp=%0d", name, err_cnt, eerr);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({pixel_we, pixel_addr, pixel_data, pkt_addr, pkt_done, pkt_error} !== '0) begin
      errors++;
      $display("FAIL %s outputs we=%b addr=%h data=%h pkt_addr=%h done=%b err=%b exp all 0",
               name, pixel_we, pixel_addr, pixel_data, pkt_addr, pkt_done, pkt_error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(2);
    clear_logs();
  endtask

  task automatic test_single();
    logic [AW-1:0] ea [4] = '{17'h123, 17'h124, 17'h125, 17'h126};
    logic [7:0]    ed [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    clear_logs();
    send_addr(24'h000123);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    idle(3);
    checks++;
    if (pkt_addr !== 24'h000123) begin
      errors++;
      $display("FAIL single pkt_addr got=%h exp=000123", pkt_addr);
    end
    check_writes("single", 4, ea, ed);
    check_counts("single", 1, 0);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [4] = '{17'd76798, 17'd76799, 17'd0, 17'd1};
    logic [7:0]    ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    send_addr(24'h012BFE);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    idle(3);
    check_writes("wrap", 4, ea, ed);
    check_counts("wrap", 1, 0);
  endtask

  task automatic test_bad_addr();
    int a_cyc;
    clear_logs();
    send_addr(24'h012C00);
    a_cyc = cyc;
    for (int i = 0; i < 8; i++) send_byte(8'h5A);
    idle(3);
    check_counts("bad_addr", 0, 1);
    checks++;
    if (log_addr.size() !== 0) begin
      errors++;
      $display("FAIL bad_addr writes got=%0d exp=0", log_addr.size());
    end
    checks++;
    if (err_cyc.size() > 0 && err_cyc[0] !== a_cyc + 1) begin
      errors++;
      $display("FAIL bad_addr err_cyc got=%0d exp=%0d", err_cyc[0], a_cyc + 1);
    end
    checks++;
    if (pkt_addr !== 24'h012C00) begin
      errors++;
      $display("FAIL bad_addr pkt_addr got=%h exp=012C00", pkt_addr);
    end
  endtask

  task automatic test_early_drop();
    logic [AW-1:0] ea [4] = '{17'h10, 17'h11, 17'h0, 17'h0};
    logic [7:0]    ed [4] = '{8'h5A, 8'h81, 8'h00, 8'h00};
    logic [AW-1:0] ea2 [4] = '{17'h200, 17'h201, 17'h202, 17'h203};
    logic [7:0]    ed2 [4] = '{8'hC3, 8'h96, 8'h0F, 8'hF0};
    int d_cyc;
    clear_logs();
    send_addr(24'h000010);
    send_pixel(8'h5A);
    send_pixel(8'h81);
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    d_cyc = cyc;
    idle(3);
    check_writes("early_drop", 2, ea, ed);
    check_counts("early_drop", 0, 1);
    checks++;
    if (err_cyc.size() > 0 && err_cyc[0] !== d_cyc + 1) begin
      errors++;
      $display("FAIL early_drop err_cyc got=%0d exp=%0d", err_cyc[0], d_cyc + 1);
    end
    // Link must recover for the following packet
    clear_logs();
    send_addr(24'h000200);
    for (int i = 0; i < 4; i++) send_pixel(ed2[i]);
    idle(3);
    check_writes("after_drop", 4, ea2, ed2);
    check_counts("after_drop", 1, 0);
  endtask

  task automatic test_trailing();
    logic [AW-1:0] ea [4] = '{17'h400, 17'h401, 17'h402, 17'h403};
    logic [7:0]    ed [4] = '{8'h01, 8'h80, 8'h7E, 8'hE7};
    clear_logs();
    send_addr(24'h000400);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    for (int i = 0; i < 8; i++) send_byte(8'hAA + 8'(i));
    idle(3);
    check_writes("trailing", 4, ea, ed);
    check_counts("trailing", 1, 0);
  endtask

  task automatic test_reset_mid_pixel();
    logic [AW-1:0] ea [4] = '{17'h500, 17'h501, 17'h502, 17'h503};
    logic [7:0]    ed [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    clear_logs();
    send_addr(24'h000300);
    send_pixel(8'h77);
    drive(1'b1, 2'b10);
    drive(1'b1, 2'b01);
    @(negedge clk);
    rst = 1'b1; axiiv = 1'b1; axiid = 2'b11;
    @(negedge clk);
    check_zero_outputs("reset_mid");
    rst = 1'b0;
    clear_logs();
    // Link stays high after reset: no packet may start without a new rising edge
    for (int i = 0; i < 6; i++) drive(1'b1, 2'b11);
    idle(2);
    checks++;
    if (log_addr.size() !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid stray writes=%0d errors=%0d exp 0/0", log_addr.size(), err_cnt);
    end
    clear_logs();
    send_addr(24'h000500);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    idle(3);
    check_writes("after_reset", 4, ea, ed);
    check_counts("after_reset", 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ea [4] = '{17'h20, 17'h21, 17'h22, 17'h23};
    logic [7:0]    ed [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_logs();
    send_addr(24'h000700);
    for (int i = 0; i < 4; i++) send_byte(8'h99);
    idle(1);
    clear_logs();
    send_addr(24'h000020);
    for (int i = 0; i < 4; i++) send_pixel(ed[i]);
    idle(3);
    check_writes("back_to_back", 4, ea, ed);
    check_counts("back_to_back", 1, 0);
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_single();
    test_wrap();
    test_bad_addr();
    test_early_drop();
    test_trailing();
    test_reset_mid_pixel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_receiver.md
Name: pixel_stream_receiver

Overview:
- Receive side of the 2-bit serial pixel link (axiiv/axiid) fed by the FPGA1 pixel transmitter.
- Deserializes each packet: one 3-byte start address, then PIXELS_PER_PKT pixel bytes, then optional trailing (audio) bytes, which are discarded.
- Issues one frame-buffer BRAM write per received pixel.
- Reports packet completion and framing errors.

Parameters:
- PIXELS_PER_PKT, 320, pixel bytes per packet after the address.
- FRAME_PIXELS, 76800, frame-buffer depth; pixel addresses wrap modulo this value.
- ADDR_W, 17, width of the frame-buffer address output.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- axiiv  input  1  link data valid; high for the whole packet, low between packets
- axiid  input  2  link dibit; axiid[1] is the more significant bit of the pair
- pixel_we  output  1  one-cycle write strobe to the frame buffer
- pixel_addr  output  ADDR_W  frame-buffer write address
- pixel_data  output  8  pixel byte to write
- pkt_addr  output  24  start address of the last packet; valid from the cycle after the address completes
- pkt_done  output  1  one-cycle pulse after PIXELS_PER_PKT pixels are written
- pkt_error  output  1  one-cycle pulse on a framing or address error

Behaviour:
- Reset:
  - One clock; rst is synchronous, active-high.
  - All outputs 0; state Idle; all counters 0.
  - Reset mid-packet abandons the packet immediately. No further pixel_we until a new axiiv rising edge after rst is released.
- Wire format:
  - Every byte is 4 dibits, least significant dibit first.
  - Dibit j of a byte fills bits [2j+1:2j].
  - Address bytes are sent most significant byte first: [23:16], then [15:8], then [7:0].
  - The address is 12 dibits; each pixel is 4 dibits.
- State Idle:
  - Waits for axiiv=1.
  - The first cycle with axiiv=1 carries address dibit 0 and is captured in that same cycle.
  - Then go to RecvAddr with the dibit count at 1.
- State RecvAddr:
  - Captures one dibit per cycle while axiiv=1.
  - On the 12th dibit, load pkt_addr with the assembled value on the next edge.
  - If the assembled address >= FRAME_PIXELS: pulse pkt_error, go to Drain.
  - Otherwise go to RecvPixel with the pixel index at 0.
- State RecvPixel:
  - Shift-assembles 4 dibits per pixel.
  - On the edge after the 4th dibit: pixel_we=1 for exactly one cycle, pixel_data = the assembled byte, pixel_addr = (start address + pixel index) mod FRAME_PIXELS. Wrap is from FRAME_PIXELS-1 to 0.
  - Latency: last dibit to pixel_we is 1 cycle.
  - The pixel index increments after each write.
  - After write number PIXELS_PER_PKT: pulse pkt_done in the same cycle as the final pixel_we, then go to Drain.
- State Drain:
  - Ignores all dibits while axiiv=1; no writes.
  - On axiiv=0, go to Idle.
- Early end:
  - axiiv=0 in RecvAddr or RecvPixel pulses pkt_error the next cycle and returns to Idle.
  - A partial pixel byte is never written. Pixels already written are kept.
- Gaps:
  - axiiv=0 is never treated as a pause; it always ends the packet.
  - Back-to-back packets need at least 1 idle cycle between them.
  - A new packet is recognized only from Idle.
- Arithmetic:
  - The address sum is computed at 18 bits, then reduced with a single conditional subtract of FRAME_PIXELS. This is valid because both operands are < FRAME_PIXELS.
- Outputs are registered. pixel_addr and pixel_data hold their last values when pixel_we=0.

Test Plan:
- Single packet, PIXELS_PER_PKT=4:
  - Stimulus: address 0x000123 as dibits 00,00,00,00 / 01,00,00,00 / 11,00,10,00, then pixels 0xA5 (dibits 01,01,10,10), 0x3C, 0xFF, 0x00.
  - Required: pkt_addr=0x000123; writes (0x123,A5), (0x124,3C), (0x125,FF), (0x126,00), each 1 cycle after its 4th dibit; pkt_done coincides with the last write.
- Wrap:
  - Stimulus: address 76798 (0x012BFE), 4 pixels.
  - Required: pixel_addr sequence 76798, 76799, 0, 1.
- Bad address:
  - Stimulus: address 76800 (0x012C00), followed by pixel dibits.
  - Required: pkt_error pulses once; zero pixel_we; returns to Idle when axiiv falls.
- Early axiiv drop:
  - Stimulus: axiiv falls after 2 full pixels plus 2 dibits.
  - Required: exactly 2 writes; pkt_error 1 cycle later; the next packet is received correctly.
- Trailing bytes:
  - Stimulus: 4 pixels plus 8 extra bytes, axiiv still high.
  - Required: exactly 4 writes; pkt_done once; no error.
- Reset mid-pixel:
  - Stimulus: assert rst during pixel 2.
  - Required: all outputs 0 the next cycle; no write for pixel 2; a following clean packet writes correctly.
